term_mult_sequencer: RTL and testbench

Sequences full-width multiplications onto the shared two-term shift-add multiplier datapath. For each operand pair it:
- recodes b into signed power-of-two terms;
- issues up to two terms per cycle to the datapath (shifts b_i/b_j, one_term, b_sign, vld);
- accumulates the returned partial products into a 2*a_N-bit product.
It sits between an upstream valid/ready operand source and a downstream valid/ready result consumer.

---
 rtl/term_mult_sequencer_if.sv | 39 +++
 rtl/term_mult_sequencer.sv | 138 +++++++++++++
 tb/tb_term_mult_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/term_mult_sequencer_if.sv
// term_mult_sequencer_if: bundle of operand, datapath and result signals around term_mult_sequencer
//   operand side : in_vld, in_rdy, a, b
//   datapath side: dp_a, dp_b_i, dp_b_j, dp_one_term, dp_b_sign, dp_vld, dp_c, dp_result_vld
//   result side  : out_vld, out_rdy, product, issue_cnt
//   slave  = sequencer view, master = environment view
interface term_mult_sequencer_if #(
    parameter int a_N = 16,
    parameter int b_N = 16,
    parameter int N   = 5
);
    logic             in_vld;
    logic             in_rdy;
    logic [a_N-1:0]   a;
    logic [b_N-1:0]   b;
    logic [a_N-1:0]   dp_a;
    logic [N-1:0]     dp_b_i;
    logic [N-1:0]     dp_b_j;
    logic             dp_one_term;
    logic             dp_b_sign;
    logic             dp_vld;
    logic [2*a_N-1:0] dp_c;
    logic             dp_result_vld;
    logic             out_vld;
    logic             out_rdy;
    logic [2*a_N-1:0] product;
    logic [N-1:0]     issue_cnt;

    modport slave (
        input  in_vld, a, b, dp_c, dp_result_vld, out_rdy,
        output in_rdy, dp_a, dp_b_i, dp_b_j, dp_one_term, dp_b_sign, dp_vld,
               out_vld, product, issue_cnt
    );

    modport master (
        output in_vld, a, b, dp_c, dp_result_vld, out_rdy,
        input  in_rdy, dp_a, dp_b_i, dp_b_j, dp_one_term, dp_b_sign, dp_vld,
               out_vld, product, issue_cnt
    );
endinterface

// File: rtl/term_mult_sequencer.sv
// term_mult_sequencer: recodes b into power-of-two terms and feeds them two at a time to a shift-add datapath
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : operand stream (in_vld/in_rdy, a, b), datapath issue/return
//                (dp_a, dp_b_i, dp_b_j, dp_one_term, dp_b_sign, dp_vld, dp_c, dp_result_vld),
//                result stream (out_vld/out_rdy, product, issue_cnt)
//   TERM_MULT_CSD_EN : when defined, b is recoded to non-adjacent form (digits +1/-1);
//                      otherwise plain binary digits and an add-only accumulator
module term_mult_sequencer #(
    parameter int a_N = 16,
    parameter int b_N = 16,
    parameter int N   = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    term_mult_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ENCODE, ISSUE, DONE} state_t;
    state_t           state, state_d;
    logic [a_N-1:0]   a_r;
    logic [b_N-1:0]   b_r;
    logic [b_N:0]     pos, nz, lp, rest, lq, left, enc_pos, enc_nz;
    logic [2*a_N-1:0] acc;
    logic [N-1:0]     cnt;
    logic             out_vld_r, out_vld_d, one, iss, retire, accept;

    // v is one-hot (or zero); returns its bit position
    function automatic logic [N-1:0] idx(input logic [b_N:0] v);
        idx = '0;
        for (int i = 0; i <= b_N; i++)
            if (v[i]) idx = N'(i);
    endfunction

`ifdef TERM_MULT_CSD_EN
    logic [b_N:0]   neg, enc_neg, hi, lo;
    logic [b_N+1:0] b3;
    logic           sp, sq, mixed, neg_all;
    // NAF digits: d = (3b >> 1) - (b >> 1), with coinciding bits cancelling
    assign b3      = {2'b0, b_r} + {1'b0, b_r, 1'b0};
    assign hi      = b3[b_N+1:1];
    assign lo      = {1'b0, b_r} >> 1;
    assign enc_pos = hi & ~lo;
    assign enc_neg = lo & ~hi;
    assign enc_nz  = enc_pos | enc_neg;
    assign nz      = pos | neg;
    assign sp      = |(lp & neg);
    assign sq      = |(lq & neg);
    assign mixed   = ~one & (sp ^ sq);
    assign neg_all = sp & (one | sq);
    // a mixed pair is issued as (+term) - (-term), so the positive digit goes to b_i
    assign bus.dp_b_i    = iss ? idx(mixed & sp ? lq : lp) : '0;
    assign bus.dp_b_j    = iss ? idx(mixed & sp ? lp : lq) : '0;
    assign bus.dp_b_sign = iss & mixed;
`else
    assign enc_pos       = {1'b0, b_r};
    assign enc_nz        = enc_pos;
    assign nz            = pos;
    assign bus.dp_b_i    = iss ? idx(lp) : '0;
    assign bus.dp_b_j    = iss ? idx(lq) : '0;
    assign bus.dp_b_sign = 1'b0;
`endif

    // two lowest nonzero digits, isolated as one-hot masks
    assign lp     = nz & -nz;
    assign rest   = nz & ~lp;
    assign lq     = rest & -rest;
    assign left   = rest & ~lq;
    assign one    = ~|rest;
    assign iss    = state == ISSUE;
    assign retire = iss & bus.dp_result_vld;
    assign accept = (state == IDLE) & bus.in_vld;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            out_vld_r <= 1'b0;
        end else begin
            state     <= state_d;
            out_vld_r <= out_vld_d;
        end

    always_comb begin
        state_d   = state;
        out_vld_d = 1'b0;
        case (state)
            IDLE:    state_d = accept ? ENCODE : IDLE;
            ENCODE:  state_d = |enc_nz ? ISSUE : DONE;
            ISSUE:   state_d = retire && ~|left ? DONE : ISSUE;
            DONE: begin
                out_vld_d = ~(out_vld_r & bus.out_rdy);
                state_d   = out_vld_r && bus.out_rdy ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            pos <= '0;
            acc <= '0;
            cnt <= '0;
`ifdef TERM_MULT_CSD_EN
            neg <= '0;
`endif
        end else begin
            if (accept) begin
                a_r <= bus.a;
                b_r <= bus.b;
            end
            if (state == ENCODE) begin
                pos <= enc_pos;
                acc <= '0;
                cnt <= '0;
`ifdef TERM_MULT_CSD_EN
                neg <= enc_neg;
`endif
            end
            if (retire) begin
                pos <= pos & ~(lp | lq);
                cnt <= cnt + N'(1);
`ifdef TERM_MULT_CSD_EN
                neg <= neg & ~(lp | lq);
                acc <= neg_all ? acc - bus.dp_c : acc + bus.dp_c;
`else
                acc <= acc + bus.dp_c;
`endif
            end
        end

    assign bus.in_rdy      = rst_n & (state == IDLE);
    assign bus.dp_a        = iss ? a_r : '0;
    assign bus.dp_one_term = iss & one;
    assign bus.dp_vld      = iss;
    assign bus.out_vld     = out_vld_r;
    assign bus.product     = acc;
    assign bus.issue_cnt   = cnt;
endmodule

// File: tb/tb_term_mult_sequencer.sv
// tb_term_mult_sequencer: vector table, stall/backpressure/reset sequences and randomized ops vs a reference model
module tb_term_mult_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    term_mult_sequencer_if #(.a_N(16), .b_N(16), .N(5)) bus ();
    term_mult_sequencer #(.a_N(16), .b_N(16), .N(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   tests = 0;
    int   fails = 0;
    logic dp_en = 1'b1;
    logic rnd_stall = 1'b0;

    // behavioural shift-add datapath answering the issued terms
    logic [63:0] ti, tj, c;
    always_comb begin
        ti = 64'(bus.dp_a) << bus.dp_b_i;
        tj = 64'(bus.dp_a) << bus.dp_b_j;
        c  = bus.dp_one_term ? ti : bus.dp_b_sign ? ti - tj : ti + tj;
    end
    assign bus.dp_c          = c[31:0];
    assign bus.dp_result_vld = bus.dp_vld & dp_en;

    typedef struct {
        logic [15:0] a, b;
        logic [31:0] prod;
        logic [4:0]  cnt, bi, bj;
        logic        one, sg, has_issue;
        int          stall, hold;
    } vec_t;
    vec_t v[5];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // issue count from the digit recoding of b, computed arithmetically
    function automatic int ref_issues(input logic [15:0] b);
        int k = 0;
`ifdef TERM_MULT_CSD_EN
        int n = int'(b);
        while (n != 0) begin
            if (n % 2 != 0) begin
                k++;
                n = n - (2 - (n % 4));
            end
            n = n / 2;
        end
`else
        for (int i = 0; i < 16; i++) k += int'(b[i]);
`endif
        return (k + 1) / 2;
    endfunction

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv, input int stall, input int hold,
                         output logic [31:0] prod, output logic [4:0] cnt, output int lat,
                         output logic seen, output logic [4:0] fbi, output logic [4:0] fbj,
                         output logic fone, output logic fsg);
        int          w;
        logic        done;
        logic [28:0] snap;
        logic [31:0] p0;
        seen = 1'b0; done = 1'b0; fbi = '0; fbj = '0; fone = 1'b0; fsg = 1'b0; lat = 0;
        @(negedge clk);
        w = 0;
        while (!bus.in_rdy && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("in_rdy_wait", 64'(bus.in_rdy), 64'(1));
        bus.a = ta; bus.b = tbv; bus.in_vld = 1'b1;
        @(negedge clk);
        bus.in_vld = 1'b0;
        while (!done && lat < 200) begin
            if (rnd_stall) dp_en = ($urandom_range(0, 2) != 0);
            if (bus.out_vld) done = 1'b1;
            else begin
                if (bus.dp_vld && !seen) begin
                    seen = 1'b1;
                    fbi = bus.dp_b_i; fbj = bus.dp_b_j; fone = bus.dp_one_term; fsg = bus.dp_b_sign;
                    if (stall > 0) begin
                        snap = {bus.dp_a, bus.dp_b_i, bus.dp_b_j, bus.dp_one_term, bus.dp_b_sign, bus.dp_vld};
                        p0 = bus.product;
                        dp_en = 1'b0;
                        for (int s = 0; s < stall; s++) begin
                            @(negedge clk);
                            lat++;
                            chk("stall_dp_hold", 64'({bus.dp_a, bus.dp_b_i, bus.dp_b_j, bus.dp_one_term,
                                                     bus.dp_b_sign, bus.dp_vld}), 64'(snap));
                            chk("stall_acc_hold", 64'(bus.product), 64'(p0));
                        end
                        dp_en = 1'b1;
                    end
                end
                @(negedge clk);
                lat++;
            end
        end
        dp_en = 1'b1;
        chk("out_vld_timeout", 64'(done), 64'(1));
        prod = bus.product;
        cnt  = bus.issue_cnt;
        if (done) begin
            chk("dp_idle_in_done", 64'({bus.dp_vld, bus.dp_a, bus.dp_b_i, bus.dp_b_j,
                                         bus.dp_one_term, bus.dp_b_sign}), 64'(0));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("bp_out_vld", 64'(bus.out_vld), 64'(1));
                chk("bp_in_rdy", 64'(bus.in_rdy), 64'(0));
                chk("bp_product", 64'(bus.product), 64'(prod));
            end
            chk("handoff_in_rdy", 64'(bus.in_rdy), 64'(0));
            bus.out_rdy = 1'b1;
            @(negedge clk);
            bus.out_rdy = 1'b0;
            chk("out_vld_drop", 64'(bus.out_vld), 64'(0));
            chk("in_rdy_rise", 64'(bus.in_rdy), 64'(1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prod;
        logic [4:0]  cnt, fbi, fbj;
        logic        seen, fone, fsg;
        int          lat;
        logic [15:0] ra, rb;

        v[0] = '{16'h0003, 16'h0000, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0};
        v[1] = '{16'h1234, 16'h0005, 32'h00005B04, 5'd1, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 0, 0};
        v[2] = '{16'h0ABC, 16'h0100, 32'h000ABC00, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 0, 0};
`ifdef TERM_MULT_CSD_EN
        v[3] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5'd1, 5'd16, 5'd0, 1'b0, 1'b1, 1'b1, 0, 0};
        v[4] = '{16'h00FF, 16'h0F0F, 32'h000EFFF1, 5'd2, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 3, 5};
`else
        v[3] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5'd8, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 0, 0};
        v[4] = '{16'h00FF, 16'h0F0F, 32'h000EFFF1, 5'd4, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 3, 5};
`endif
        bus.in_vld = 1'b0; bus.out_rdy = 1'b0; bus.a = '0; bus.b = '0;

        #1 rst_n = 1'b0;
        #11;
        chk("rst_in_rdy", 64'(bus.in_rdy), 64'(0));
        chk("rst_outputs", 64'({bus.dp_vld, bus.dp_a, bus.dp_b_i, bus.dp_b_j, bus.dp_one_term,
                                 bus.dp_b_sign, bus.out_vld}), 64'(0));
        chk("rst_product", 64'(bus.product), 64'(0));
        chk("rst_issue_cnt", 64'(bus.issue_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_in_rdy", 64'(bus.in_rdy), 64'(1));

        for (int i = 0; i < 5; i++) begin
            do_op(v[i].a, v[i].b, v[i].stall, v[i].hold, prod, cnt, lat, seen, fbi, fbj, fone, fsg);
            chk($sformatf("vec%0d_product", i), 64'(prod), 64'(v[i].prod));
            chk($sformatf("vec%0d_issue_cnt", i), 64'(cnt), 64'(v[i].cnt));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(2 + int'(v[i].cnt) + v[i].stall));
            chk($sformatf("vec%0d_dp_seen", i), 64'(seen), 64'(v[i].has_issue));
            if (v[i].has_issue)
                chk($sformatf("vec%0d_first_issue", i), 64'({fbi, fbj, fone, fsg}),
                    64'({v[i].bi, v[i].bj, v[i].one, v[i].sg}));
        end

        // reset in the middle of a long operation
        @(negedge clk);
        bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.in_vld = 1'b1;
        @(negedge clk);
        bus.in_vld = 1'b0;
        for (int w = 0; w < 10 && !bus.dp_vld; w++) @(negedge clk);
        chk("mid_dp_vld", 64'(bus.dp_vld), 64'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_in_rdy", 64'(bus.in_rdy), 64'(0));
        chk("async_rst_dp", 64'({bus.dp_vld, bus.dp_a, bus.dp_b_i, bus.dp_b_j, bus.dp_one_term,
                                  bus.dp_b_sign}), 64'(0));
        chk("async_rst_out", 64'({bus.out_vld, bus.product, bus.issue_cnt}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("after_rst_in_rdy", 64'(bus.in_rdy), 64'(1));
        do_op(16'd2, 16'd3, 0, 0, prod, cnt, lat, seen, fbi, fbj, fone, fsg);
        chk("after_rst_product", 64'(prod), 64'(6));
        chk("after_rst_issue_cnt", 64'(cnt), 64'(1));

        // randomized operands against the arithmetic model
        for (int r = 0; r < 40; r++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            rnd_stall = (r % 2) == 1;
            do_op(ra, rb, 0, $urandom_range(0, 2), prod, cnt, lat, seen, fbi, fbj, fone, fsg);
            chk($sformatf("rnd%0d_product a=%0h b=%0h", r, ra, rb), 64'(prod), 64'(32'(ra) * 32'(rb)));
            chk($sformatf("rnd%0d_issue_cnt", r), 64'(cnt), 64'(ref_issues(rb)));
            if (!rnd_stall)
                chk($sformatf("rnd%0d_latency", r), 64'(lat), 64'(2 + ref_issues(rb)));
        end
        rnd_stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
